// File: rtl/dt_pkg.sv
// Shared definitions for the distance-transform datapath: image geometry,
// address widths and the loader state encoding.
package dt_pkg;

    localparam int IMG_W   = 128;
    localparam int WORD_W  = 16;
    localparam int N_WORDS = IMG_W * IMG_W / WORD_W;
    localparam int STI_AW  = 10;
    localparam int RES_AW  = 14;
    localparam int PIX_W   = 8;
    localparam int CNT_W   = 15;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_FETCH,
        LD_WRITE,
        LD_DONE
    } ld_state_e;

endpackage

// File: rtl/dt_bit_ser.sv
// Load/shift register that presents a ROM word one bit per cycle, MSB first,
// with a flag marking the last bit of the word.
module dt_bit_ser
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              bit_o,
    output logic              last_o
);

    logic [WORD_W-1:0] shreg_q;
    logic [3:0]        cnt_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
            cnt_q   <= '0;
        end else if (shift_i) begin
            shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
            cnt_q   <= cnt_q + 4'd1;
        end
    end

    assign bit_o  = shreg_q[WORD_W-1];
    assign last_o = (cnt_q == 4'(WORD_W - 1));

endmodule

// File: rtl/dt_img_loader.sv
// Unpacks the 1024x16 packed binary image from the stimulus ROM into one byte
// per pixel in the result RAM. Define LD_SKIP_ZERO_EN to skip all-zero words.
module dt_img_loader
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sti_rd,
    output logic [STI_AW-1:0] sti_addr,
    input  logic [WORD_W-1:0] sti_di,
    output logic              res_wr,
    output logic [RES_AW-1:0] res_addr,
    output logic [PIX_W-1:0]  res_do,
    output logic [CNT_W-1:0]  obj_cnt
);

    ld_state_e         state_q;
    logic [STI_AW-1:0] w_q;
    logic [STI_AW-1:0] w_d;
    logic              busy_q;
    logic              done_q;
    logic              sti_rd_q;
    logic [STI_AW-1:0] sti_addr_q;
    logic              res_wr_q;
    logic [RES_AW-1:0] res_addr_q;
    logic [CNT_W-1:0]  obj_cnt_q;
    logic              ser_bit;
    logic              ser_last;
    logic              last_word;

    assign w_d       = w_q + 1'b1;
    assign last_word = (w_q == STI_AW'(N_WORDS - 1));

    dt_bit_ser u_bit_ser (
        .clk     (clk),
        .reset   (reset),
        .load_i  (state_q == LD_FETCH),
        .shift_i (state_q == LD_WRITE),
        .data_i  (sti_di),
        .bit_o   (ser_bit),
        .last_o  (ser_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= LD_IDLE;
            w_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sti_rd_q   <= 1'b0;
            sti_addr_q <= '0;
            res_wr_q   <= 1'b0;
            res_addr_q <= '0;
            obj_cnt_q  <= '0;
        end else begin
            case (state_q)
                LD_IDLE, LD_DONE: begin
                    if (start) begin
                        state_q    <= LD_FETCH;
                        w_q        <= '0;
                        obj_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        sti_rd_q   <= 1'b1;
                        sti_addr_q <= '0;
                    end
                end

                LD_FETCH: begin
`ifdef LD_SKIP_ZERO_EN
                    // Relies on a pre-zeroed RAM: a blank word needs no writes.
                    if (sti_di == '0) begin
                        if (last_word) begin
                            state_q    <= LD_DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            sti_rd_q   <= 1'b0;
                            sti_addr_q <= '0;
                            res_addr_q <= '0;
                        end else begin
                            w_q        <= w_d;
                            sti_addr_q <= w_d;
                        end
                    end else
`endif
                    begin
                        state_q    <= LD_WRITE;
                        sti_rd_q   <= 1'b0;
                        res_wr_q   <= 1'b1;
                        res_addr_q <= {w_q, 4'd0};
                    end
                end

                LD_WRITE: begin
                    obj_cnt_q <= obj_cnt_q + CNT_W'(ser_bit);
                    if (!ser_last) begin
                        res_addr_q <= res_addr_q + 1'b1;
                    end else if (last_word) begin
                        state_q    <= LD_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        res_wr_q   <= 1'b0;
                        sti_addr_q <= '0;
                        res_addr_q <= '0;
                    end else begin
                        state_q    <= LD_FETCH;
                        w_q        <= w_d;
                        res_wr_q   <= 1'b0;
                        sti_rd_q   <= 1'b1;
                        sti_addr_q <= w_d;
                    end
                end

                default: state_q <= LD_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sti_rd   = sti_rd_q;
    assign sti_addr = sti_addr_q;
    assign res_wr   = res_wr_q;
    assign res_addr = res_addr_q;
    assign res_do   = {7'b0, ser_bit & res_wr_q};
    assign obj_cnt  = obj_cnt_q;

endmodule

// File: tb/tb_dt_img_loader.sv
// Directed/randomized bench for dt_img_loader with a ROM/RAM model and a
// pixel-level reference image. Honours LD_SKIP_ZERO_EN when defined.
module tb_dt_img_loader;
    import dt_pkg::*;

    localparam int PIX   = IMG_W * IMG_W;
    localparam int LIMIT = 20000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic              sti_rd;
    logic [STI_AW-1:0] sti_addr;
    logic [WORD_W-1:0] sti_di = '0;
    logic              res_wr;
    logic [RES_AW-1:0] res_addr;
    logic [PIX_W-1:0]  res_do;
    logic [CNT_W-1:0]  obj_cnt;

    logic [WORD_W-1:0] rom [N_WORDS];
    logic [PIX_W-1:0]  ram [PIX];

    int                checks = 0;
    int                errors = 0;
    int                wr_cnt = 0;
    int                seq_err = 0;
    int                both_err = 0;
    logic [RES_AW-1:0] last_addr = '0;

    dt_img_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .sti_rd   (sti_rd),
        .sti_addr (sti_addr),
        .sti_di   (sti_di),
        .res_wr   (res_wr),
        .res_addr (res_addr),
        .res_do   (res_do),
        .obj_cnt  (obj_cnt)
    );

    always #5 clk = ~clk;

    // Stimulus ROM registers its output on the falling edge.
    always @(negedge clk) begin
        if (sti_rd) sti_di <= rom[sti_addr];
    end

    // Result RAM plus write-order and strobe-exclusion monitors.
    always @(posedge clk) begin
        if (res_wr) begin
            ram[res_addr] <= res_do;
            if (wr_cnt > 0 && res_addr <= last_addr) seq_err <= seq_err + 1;
            last_addr <= res_addr;
            wr_cnt    <= wr_cnt + 1;
        end
        if (sti_rd && res_wr) both_err <= both_err + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: cost, write count and population from the packed image.
    function automatic int model_cycles();
        int n = 0;
        for (int i = 0; i < N_WORDS; i++) begin
`ifdef LD_SKIP_ZERO_EN
            n += (rom[i] == 16'h0) ? 1 : WORD_W + 1;
`else
            n += WORD_W + 1;
`endif
        end
        return n;
    endfunction

    function automatic int model_writes();
        int n = 0;
        for (int i = 0; i < N_WORDS; i++) begin
`ifdef LD_SKIP_ZERO_EN
            if (rom[i] != 16'h0) n += WORD_W;
`else
            n += WORD_W;
`endif
        end
        return n;
    endfunction

    function automatic int model_obj();
        int n = 0;
        for (int i = 0; i < N_WORDS; i++) n += $countones(rom[i]);
        return n;
    endfunction

    // Pixel (r,c) lives in word r*8 + c/16, leftmost pixel in the word MSB.
    function automatic int ram_mismatches();
        int bad = 0;
        for (int r = 0; r < IMG_W; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                int         wi;
                logic [7:0] exp_pix;
                wi      = r * (IMG_W / WORD_W) + c / WORD_W;
                exp_pix = {7'b0, rom[wi][WORD_W - 1 - (c % WORD_W)]};
                if (ram[r * IMG_W + c] !== exp_pix) bad++;
            end
        end
        return bad;
    endfunction

    task automatic fill_ram();
        for (int i = 0; i < PIX; i++) begin
`ifdef LD_SKIP_ZERO_EN
            ram[i] = 8'h00;
`else
            ram[i] = 8'hAA;
`endif
        end
    endtask

    task automatic fill_rom_random();
        for (int i = 0; i < N_WORDS; i++)
            rom[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    endtask

    // One full load; busy_word >= 0 pulses start during FETCH of that word.
    task automatic run_load(input string tag, input int busy_word);
        int                n = 0;
        bit                pulsed = 1'b0;
        logic              prev_wr = 1'b0;
        logic [RES_AW-1:0] prev_addr = '0;
        bit                first_wr;
        bit                last_wr;
`ifdef LD_SKIP_ZERO_EN
        first_wr = (rom[0] != 16'h0);
        last_wr  = (rom[N_WORDS-1] != 16'h0);
`else
        first_wr = 1'b1;
        last_wr  = 1'b1;
`endif
        wr_cnt = 0; seq_err = 0; both_err = 0; last_addr = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, ".fetch"}, {busy, done, sti_rd, res_wr, sti_addr}, {4'b1010, 10'd0});
        while (!done && n < LIMIT) begin
            prev_wr   = res_wr;
            prev_addr = res_addr;
            if (busy_word >= 0 && !pulsed && sti_rd && sti_addr == STI_AW'(busy_word)) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
            if (n == 1 && first_wr)
                check({tag, ".first_wr"}, {res_wr, sti_rd, res_addr}, {2'b10, 14'd0});
        end
        check({tag, ".cycles"}, n, model_cycles());
        check({tag, ".done_outs"}, {busy, done, sti_rd, res_wr}, 4'b0100);
        if (last_wr)
            check({tag, ".last_wr"}, {prev_wr, prev_addr}, {1'b1, 14'h3FFF});
        check({tag, ".obj_cnt"}, obj_cnt, model_obj());
        check({tag, ".wr_cnt"}, wr_cnt, model_writes());
        check({tag, ".addr_order"}, seq_err, 0);
        check({tag, ".rd_wr_excl"}, both_err, 0);
        check({tag, ".ram"}, ram_mismatches(), 0);
    endtask

    initial begin
        int            n;
        logic [CNT_W-1:0] first_obj;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset.outs", {busy, done, sti_rd, res_wr, sti_addr, res_addr, res_do, obj_cnt}, '0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle.outs", {busy, done, sti_rd, res_wr, sti_addr, res_addr, res_do, obj_cnt}, '0);

        // Sparse corner pixels: first, sixteenth and very last pixel set.
        for (int i = 0; i < N_WORDS; i++) rom[i] = 16'h0;
        rom[0]         = 16'h8001;
        rom[N_WORDS-1] = 16'h0001;
        fill_ram();
        run_load("sparse", -1);
        check("sparse.ram0", ram[0], 8'h01);
        check("sparse.ram1", ram[1], 8'h00);
        check("sparse.ram15", ram[15], 8'h01);
        check("sparse.ram_last", ram[PIX-1], 8'h01);
        check("sparse.obj3", obj_cnt, 15'd3);

        // Solid image: counter reaches its maximum without saturating.
        for (int i = 0; i < N_WORDS; i++) rom[i] = 16'hFFFF;
        fill_ram();
        run_load("solid", -1);
        check("solid.obj_max", obj_cnt, 15'h4000);
        repeat (3) @(negedge clk);
        check("solid.done_held", {done, busy}, 2'b10);

`ifdef LD_SKIP_ZERO_EN
        for (int i = 0; i < N_WORDS; i++) rom[i] = 16'h0;
        fill_ram();
        run_load("blank", -1);
        check("blank.no_writes", wr_cnt, 0);
        check("blank.obj0", obj_cnt, 15'd0);
`endif

        // Random image, aborted by reset during WRITE of word 5.
        fill_rom_random();
        rom[N_WORDS-1] = 16'h0001;
        rom[5]         = 16'hA5A5;
        fill_ram();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(res_wr && res_addr == 14'd84) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("abort.reach_word5", n < LIMIT, 1'b1);
        #2 reset = 1'b0;
        #1 check("abort.async_outs",
                 {busy, done, sti_rd, res_wr, sti_addr, res_addr, res_do, obj_cnt}, '0);
        @(negedge clk) reset = 1'b1;

        // Reload after abort with a start pulse while busy at word 300.
        fill_ram();
        run_load("busy_start", 300);
        first_obj = obj_cnt;

        // Second start after done repeats the load identically.
        fill_ram();
        run_load("repeat", -1);
        check("repeat.same_obj", obj_cnt, first_obj);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
